// File: rtl/cmd_parse.sv
// Serial command parser: "*" letter [4 hex digits] CR writes config registers and returns
// an ACK ("-") or NAK ("!") through a single-entry response buffer.
module cmd_parse #(
  parameter logic [15:0] NSAMP_DEF    = 16'h0010,
  parameter logic [15:0] PRESCALE_DEF = 16'h0020,
  parameter logic [15:0] SPEED_DEF    = 16'h0001
) (
  input  logic        clk_rx,
  input  logic        rst_clk_rx,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  output logic [7:0]  resp_char,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_ovr,
  output logic [15:0] nsamp,
  output logic [15:0] prescale,
  output logic [15:0] speed,
  output logic        gen_en
);

  localparam logic [7:0] ChStar = 8'h2A;
  localparam logic [7:0] ChCr   = 8'h0D;
  localparam logic [7:0] ChAck  = 8'h2D;
  localparam logic [7:0] ChNak  = 8'h21;

  typedef enum logic [1:0] {StIdle, StCmd, StHex, StEol} state_e;

  state_e      state;
  logic [7:0]  letter;
  logic [15:0] value;
  logic [1:0]  count;

  logic [7:0]  ch_up;
  logic        is_hex;
  logic [3:0]  nibble;
  logic        is_nps;
  logic        is_gh;
  logic        gen_resp;
  logic [7:0]  gen_char;

  always_comb begin
    ch_up  = ((rx_data >= 8'h61) && (rx_data <= 8'h7A)) ? (rx_data - 8'h20) : rx_data;
    is_hex = 1'b0;
    nibble = 4'h0;
    if ((ch_up >= 8'h30) && (ch_up <= 8'h39)) begin
      is_hex = 1'b1;
      nibble = ch_up[3:0];
    end else if ((ch_up >= 8'h41) && (ch_up <= 8'h46)) begin
      is_hex = 1'b1;
      nibble = ch_up[3:0] + 4'd9;
    end
    is_nps = (ch_up == 8'h4E) || (ch_up == 8'h50) || (ch_up == 8'h53);
    is_gh  = (ch_up == 8'h47) || (ch_up == 8'h48);
  end

  // "*" always restarts silently, so it never produces a response.
  always_comb begin
    gen_resp = 1'b0;
    gen_char = ChNak;
    if (rx_data_rdy && (rx_data != ChStar)) begin
      unique case (state)
        StIdle: gen_resp = 1'b0;
        StCmd:  gen_resp = !(is_nps || is_gh);
        StHex:  gen_resp = !is_hex;
        StEol: begin
          gen_resp = 1'b1;
          gen_char = (rx_data == ChCr) ? ChAck : ChNak;
        end
        default: gen_resp = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
    if (rst_clk_rx) begin
      state      <= StIdle;
      letter     <= 8'h00;
      value      <= 16'h0000;
      count      <= 2'd0;
      resp_char  <= 8'h00;
      resp_valid <= 1'b0;
      resp_ovr   <= 1'b0;
      nsamp      <= NSAMP_DEF;
      prescale   <= PRESCALE_DEF;
      speed      <= SPEED_DEF;
      gen_en     <= 1'b0;
    end else begin
      resp_ovr <= 1'b0;
      if (gen_resp) begin
        resp_char  <= gen_char;
        resp_valid <= 1'b1;
        resp_ovr   <= resp_valid && !resp_ready;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end

      if (rx_data_rdy) begin
        if (rx_data == ChStar) begin
          state <= StCmd;
        end else begin
          unique case (state)
            StIdle: state <= StIdle;
            StCmd: begin
              letter <= ch_up;
              value  <= 16'h0000;
              count  <= 2'd0;
              if (is_nps)     state <= StHex;
              else if (is_gh) state <= StEol;
              else            state <= StIdle;
            end
            StHex: begin
              if (is_hex) begin
                value <= {value[11:0], nibble};
                count <= count + 2'd1;
                if (count == 2'd3) state <= StEol;
              end else begin
                state <= StIdle;
              end
            end
            StEol: begin
              state <= StIdle;
              if (rx_data == ChCr) begin
                unique case (letter)
                  8'h4E:   nsamp    <= value;
                  8'h50:   prescale <= value;
                  8'h53:   speed    <= value;
                  8'h47:   gen_en   <= 1'b1;
                  8'h48:   gen_en   <= 1'b0;
                  default: gen_en   <= gen_en;
                endcase
              end
            end
            default: state <= StIdle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_parse.sv
// Scoreboard bench for cmd_parse: directed command strings push expected responses, a
// negedge monitor pops them on each accepted response.
module tb_cmd_parse;

  logic        clk_rx = 1'b0;
  logic        rst_clk_rx = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_rdy = 1'b0;
  logic [7:0]  resp_char;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_ovr;
  logic [15:0] nsamp, prescale, speed;
  logic        gen_en;

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_cnt = 0;
  logic [7:0] exp_q[$];

  localparam logic [7:0] Ack = 8'h2D;
  localparam logic [7:0] Nak = 8'h21;
  localparam logic [7:0] Cr  = 8'h0D;

  cmd_parse dut (
    .clk_rx      (clk_rx),
    .rst_clk_rx  (rst_clk_rx),
    .rx_data     (rx_data),
    .rx_data_rdy (rx_data_rdy),
    .resp_char   (resp_char),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_ovr    (resp_ovr),
    .nsamp       (nsamp),
    .prescale    (prescale),
    .speed       (speed),
    .gen_en      (gen_en)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_rx) begin
    if (!rst_clk_rx) begin
      if (resp_ovr) ovr_cnt++;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: got %h expected none", resp_char);
        end else begin
          check("resp_char", {8'h00, resp_char}, {8'h00, exp_q.pop_front()});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the character has been sampled.
  task automatic send_char(input logic [7:0] c);
    rx_data     = c;
    rx_data_rdy = 1'b1;
    @(posedge clk_rx);
    #1;
    rx_data_rdy = 1'b0;
  endtask

  task automatic send_str(input string s, input bit with_cr);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    if (with_cr) send_char(Cr);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_rx);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {15'd0, resp_valid}, 16'h0000);
    check({tag, "_char"}, {8'h00, resp_char}, 16'h0000);
    check({tag, "_ovr"}, {15'd0, resp_ovr}, 16'h0000);
    check({tag, "_nsamp"}, nsamp, 16'h0010);
    check({tag, "_prescale"}, prescale, 16'h0020);
    check({tag, "_speed"}, speed, 16'h0001);
    check({tag, "_gen_en"}, {15'd0, gen_en}, 16'h0000);
  endtask

  task automatic do_reset();
    @(posedge clk_rx);
    #3 rst_clk_rx = 1'b1;
    @(posedge clk_rx);
    #1 rst_clk_rx = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk_rx);
    #1;
    check_reset_outputs("reset");
    rst_clk_rx = 1'b0;
    idle(2);

    // Basic write, lowercase hex, G/H.
    exp_q.push_back(Ack);
    send_str("*N00A5", 1);
    check("n_nsamp", nsamp, 16'h00A5);
    check("n_prescale", prescale, 16'h0020);
    check("n_speed", speed, 16'h0001);
    exp_q.push_back(Ack);
    send_str("*pBeEf", 1);
    check("p_prescale", prescale, 16'hBEEF);
    exp_q.push_back(Ack);
    send_str("*G", 1);
    check("g_gen_en", {15'd0, gen_en}, 16'h0001);
    exp_q.push_back(Ack);
    send_str("*h", 1);
    check("h_gen_en", {15'd0, gen_en}, 16'h0000);

    // Bad hex digit, then trailing junk in IDLE.
    exp_q.push_back(Nak);
    send_str("*S12G4", 1);
    check("s_bad_speed", speed, 16'h0001);
    idle(3);

    // Restart mid-command from a fresh reset.
    do_reset();
    exp_q.push_back(Ack);
    send_str("*N12*S0003", 1);
    check("restart_speed", speed, 16'h0003);
    check("restart_nsamp", nsamp, 16'h0010);
    idle(3);

    // Overwrite while downstream stalls.
    resp_ready = 1'b0;
    send_str("*G", 1);
    check("stall_valid", {15'd0, resp_valid}, 16'h0001);
    check("stall_char", {8'h00, resp_char}, {8'h00, Ack});
    check("stall_gen_en", {15'd0, gen_en}, 16'h0001);
    send_str("*X", 0);
    check("ovr_char", {8'h00, resp_char}, {8'h00, Nak});
    check("ovr_pulse", {15'd0, resp_ovr}, 16'h0001);
    idle(3);
    check("hold_valid", {15'd0, resp_valid}, 16'h0001);
    check("hold_ovr", {15'd0, resp_ovr}, 16'h0000);
    exp_q.push_back(Nak);
    resp_ready = 1'b1;
    idle(2);
    check("drain_valid", {15'd0, resp_valid}, 16'h0000);

    // Asynchronous reset mid-command, outputs clear before the next edge.
    send_str("*N12", 0);
    #3 rst_clk_rx = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk_rx);
    #1 rst_clk_rx = 1'b0;
    send_str("34", 1);
    check("post_rst_nsamp", nsamp, 16'h0010);
    idle(3);

    // Character in the first cycle after deassertion is processed.
    @(posedge clk_rx);
    #3 rst_clk_rx = 1'b1;
    @(posedge clk_rx);
    #1 rst_clk_rx = 1'b0;
    exp_q.push_back(Ack);
    send_str("*G", 1);
    check("first_cycle_gen_en", {15'd0, gen_en}, 16'h0001);
    idle(5);

    check("queue_empty", 16'(exp_q.size()), 16'h0000);
    check("ovr_count", 16'(ovr_cnt), 16'h0001);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_parse.md
CMD_PARSE -- requirements
Module: cmd_parse

Interface
REQ-001 SHALL have parameter NSAMP_DEF, default 16'h0010: reset value of nsamp.
REQ-002 SHALL have parameter PRESCALE_DEF, default 16'h0020: reset value of prescale.
REQ-003 SHALL have parameter SPEED_DEF, default 16'h0001: reset value of speed.
REQ-004 SHALL have port clk_rx, input, 1: single clock, rising edge; the block has one clock.
REQ-005 SHALL have port rst_clk_rx, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port rx_data, input, 8: received ASCII character, valid only while rx_data_rdy=1.
REQ-007 SHALL have port rx_data_rdy, input, 1: one-cycle strobe from the UART receiver.
REQ-008 SHALL have port resp_char, output, 8: response character ("-" = ACK, "!" = NAK).
REQ-009 SHALL have port resp_valid, output, 1: resp_char holds a pending response.
REQ-010 SHALL have port resp_ready, input, 1: downstream transmitter accepts resp_char.
REQ-011 SHALL have port resp_ovr, output, 1: one-cycle pulse when a pending response is replaced.
REQ-012 SHALL have ports nsamp, prescale and speed, output, 16 each: command-written registers.
REQ-013 SHALL have port gen_en, output, 1: waveform generation enable.

Function
REQ-014 SHALL accept the command grammar "*" letter [4 hex digits] CR (8'h0D); letters N, P and S take 4 digits; G and H take none.
REQ-015 SHALL match command letters and hex digits A-F case-insensitively.
REQ-016 SHALL implement states IDLE, CMD, HEX and EOL, with IDLE as the reset state.
REQ-017 SHALL act only on cycles with rx_data_rdy=1; other cycles hold state.
REQ-018 IDLE: "*" goes to CMD; any other character is ignored with no response.
REQ-019 CMD: N/P/S latch the letter, clear the digit count and the 16-bit shift value, then go to HEX; G/H go to EOL; any other character goes to IDLE and issues NAK.
REQ-020 HEX: each hex digit sets value = {value[11:0], nibble}; the 4th digit goes to EOL; a non-hex character goes to IDLE and issues NAK.
REQ-021 EOL: CR executes the command, issues ACK and goes to IDLE; any other character goes to IDLE and issues NAK.
REQ-022 Execution updates the target register in the same cycle the CR is accepted: N writes nsamp, P writes prescale, S writes speed, G sets gen_en=1, H sets gen_en=0.
REQ-023 "*" received in CMD, HEX or EOL SHALL restart to CMD and discard the partial command with no response; this check takes priority over REQ-019..021.
REQ-024 A response SHALL appear as resp_valid=1 with resp_char set, on the cycle after the terminating character.
REQ-025 resp_valid SHALL clear on the cycle after resp_valid=1 and resp_ready=1; resp_char SHALL stay stable while resp_valid=1 and not accepted.
REQ-026 If a new response is generated while resp_valid=1 and resp_ready=0, resp_char SHALL take the new value, resp_valid SHALL stay 1, and resp_ovr SHALL pulse for one cycle.
REQ-027 If a new response coincides with acceptance of the old one (resp_ready=1), the new one SHALL load with resp_valid staying 1 and no resp_ovr.
REQ-028 Register writes SHALL occur regardless of the response handshake state.

Reset
REQ-029 Asserting rst_clk_rx SHALL immediately force the state to IDLE, clear the value and count, and set resp_valid=0, resp_char=8'h00, resp_ovr=0, nsamp=NSAMP_DEF, prescale=PRESCALE_DEF, speed=SPEED_DEF and gen_en=0.
REQ-030 Reset asserted mid-command SHALL discard the partial command; after deassertion a character arriving in the first cycle SHALL be processed.

Verification
REQ-031 Send "*N00A5\r" with resp_ready=1 -> nsamp=16'h00A5 on CR, one "-" response, prescale and speed unchanged.
REQ-032 Send "*pBeEf\r" -> prescale=16'hBEEF, ACK; then send "*G\r" -> gen_en=1, ACK; then send "*h\r" -> gen_en=0, ACK.
REQ-033 Send "*S12G4\r" -> NAK on "G", speed stays 16'h0001, and the trailing "4\r" produces no response.
REQ-034 Send "*N12*S0003\r" -> no response for the aborted N, speed=16'h0003, nsamp=16'h0010, exactly one ACK.
REQ-035 Hold resp_ready=0 and send "*G\r" then "*X" -> resp_char changes from "-" to "!", one resp_ovr pulse, resp_valid stays 1 until resp_ready=1.
REQ-036 Assert rst_clk_rx after "*N12" and after gen_en=1 -> all outputs return to reset values within the reset cycle; then "34\r" produces no response and nsamp stays 16'h0010.
